// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes SPI command words into RAM accesses and shares
// the single RAM port with a parallel host using round-robin arbitration.
// Build option: define SPI_RAM_AUTOINC_EN to auto-increment the SPI
// write/read address registers each time an SPI data op is granted.
// The payload-to-address mapping assumes ADDR_W <= DATA_W (truncation).
module spi_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              spi_ovf,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RD
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] pay;
  logic [ADDR_W-1:0] pay_addr;
  logic              set_wr;
  logic              set_rd;
  logic              data_cmd;

  logic              slot_v_q;
  logic              slot_we_q;
  logic [ADDR_W-1:0] slot_addr_q;
  logic [DATA_W-1:0] slot_data_q;
  logic              slot_free;
  logic              slot_full;

  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              ovf_q;

  logic              last_host_q;
  logic              cur_host_q;
  logic              cur_we_q;

  logic              gnt_spi;
  logic              gnt_host;
  logic              gnt_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              h_gnt_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic [DATA_W-1:0] h_rdata_q;
  logic              h_rvalid_q;

  assign cmd      = rx_data[DATA_W+1:DATA_W];
  assign pay      = rx_data[DATA_W-1:0];
  assign pay_addr = ADDR_W'(pay);
  assign set_wr   = rx_valid && (cmd == 2'b00);
  assign set_rd   = rx_valid && (cmd == 2'b10);
  assign data_cmd = rx_valid && cmd[0];

  // The slot empties at the end of an SPI access cycle, so a data word
  // arriving in that very cycle may refill it.
  assign slot_free = (state_q == ACC) && !cur_host_q;
  assign slot_full = slot_v_q && !slot_free;

  assign gnt_any  = gnt_spi || gnt_host;
  assign sel_we   = gnt_host ? h_we    : slot_we_q;
  assign sel_addr = gnt_host ? h_addr  : slot_addr_q;
  assign sel_din  = gnt_host ? h_wdata : slot_data_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Round-robin grant decision and next-state logic
  always_comb begin
    state_d  = state_q;
    gnt_spi  = 1'b0;
    gnt_host = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slot_v_q && h_req) begin
          gnt_spi  = last_host_q;
          gnt_host = !last_host_q;
        end else begin
          gnt_spi  = slot_v_q;
          gnt_host = h_req;
        end
        if (gnt_spi || gnt_host) state_d = ACC;
      end
      ACC:     state_d = cur_we_q ? IDLE : RD;
      RD:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register the winning access onto the RAM port for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_host_q <= 1'b1;
      cur_host_q  <= 1'b0;
      cur_we_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      h_gnt_q     <= 1'b0;
    end else begin
      ram_en_q <= gnt_any;
      ram_we_q <= gnt_any && sel_we;
      h_gnt_q  <= gnt_host;
      if (gnt_any) begin
        last_host_q <= gnt_host;
        cur_host_q  <= gnt_host;
        cur_we_q    <= sel_we;
        ram_addr_q  <= sel_addr;
        if (sel_we) ram_din_q <= sel_din;
      end
    end
  end

  // Single-entry SPI pending slot and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_v_q    <= 1'b0;
      slot_we_q   <= 1'b0;
      slot_addr_q <= '0;
      slot_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (slot_free) slot_v_q <= 1'b0;
      if (data_cmd) begin
        if (slot_full) begin
          ovf_q <= 1'b1;
        end else begin
          slot_v_q    <= 1'b1;
          slot_we_q   <= !cmd[1];
          slot_addr_q <= cmd[1] ? rd_addr_q : wr_addr_q;
          slot_data_q <= pay;
        end
      end
    end
  end

  // SPI address registers; an explicit set beats an auto-increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
`ifdef SPI_RAM_AUTOINC_EN
      if (gnt_spi && slot_we_q)  wr_addr_q <= wr_addr_q + ADDR_W'(1);
      if (gnt_spi && !slot_we_q) rd_addr_q <= rd_addr_q + ADDR_W'(1);
`else
`endif
      if (set_wr) wr_addr_q <= pay_addr;
      if (set_rd) rd_addr_q <= pay_addr;
    end
  end

  // Capture read data in RD and steer it to the side that issued the read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      h_rdata_q  <= '0;
      h_rvalid_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      if (state_q == RD) begin
        if (cur_host_q) begin
          h_rdata_q  <= ram_dout;
          h_rvalid_q <= 1'b1;
        end else begin
          tx_data_q  <= ram_dout;
          tx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign ram_en   = ram_en_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign h_gnt    = h_gnt_q;
  assign h_rdata  = h_rdata_q;
  assign h_rvalid = h_rvalid_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign spi_ovf  = ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: scoreboard bench for spi_ram_arbiter with a
// behavioural RAM, directed scenarios and randomized SPI/host traffic.
module tb_spi_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW+1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          spi_ovf;
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic [DW-1:0] h_rdata;
  logic          h_rvalid;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .spi_ovf(spi_ovf),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } op_t;

  logic [DW-1:0] ref_mem [256];
  op_t           sq[$];
  op_t           hq[$];
  logic [DW-1:0] sdq[$];
  logic [DW-1:0] hdq[$];
  int            scyc[$];
  int            hcyc[$];
  int            glog[$];
  logic [AW-1:0] m_wr;
  logic [AW-1:0] m_rd;
  int            total = 0;
  int            passed = 0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every RAM access, tx and host return pops the scoreboard
  always @(negedge clk) begin : mon
    op_t e;
    int  c;
    if (!rst) begin
      if (ram_en) begin
        if (h_gnt) begin
          glog.push_back(2);
          if (hq.size() == 0) chk("host_ram_unexpected", 1, 0);
          else begin
            e = hq.pop_front();
            chk("host_ram_we", ram_we, e.we);
            chk("host_ram_addr", ram_addr, e.addr);
            if (e.we) chk("host_ram_din", ram_din, e.din);
            else hcyc.push_back(cyc);
          end
        end else begin
          glog.push_back(1);
          if (sq.size() == 0) chk("spi_ram_unexpected", 1, 0);
          else begin
            e = sq.pop_front();
            chk("spi_ram_we", ram_we, e.we);
            chk("spi_ram_addr", ram_addr, e.addr);
            if (e.we) chk("spi_ram_din", ram_din, e.din);
            else scyc.push_back(cyc);
          end
        end
      end
      if (tx_valid) begin
        if (sdq.size() == 0 || scyc.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          chk("tx_data", tx_data, sdq.pop_front());
          c = scyc.pop_front();
          chk("tx_latency", cyc - c, 2);
        end
      end
      if (h_rvalid) begin
        if (hdq.size() == 0 || hcyc.size() == 0) chk("h_rvalid_unexpected", 1, 0);
        else begin
          chk("h_rdata", h_rdata, hdq.pop_front());
          c = hcyc.pop_front();
          chk("h_latency", cyc - c, 2);
        end
      end
    end
  end

  // Drive one SPI word and record its expected effect
  task automatic spi_word(input logic [9:0] w, input bit drop = 1'b0);
    logic [7:0] p;
    p = w[7:0];
    @(negedge clk);
    rx_data  = w;
    rx_valid = 1'b1;
    case (w[9:8])
      2'b00: m_wr = p;
      2'b10: m_rd = p;
      2'b01: if (!drop) begin
        sq.push_back('{we: 1'b1, addr: m_wr, din: p});
        ref_mem[m_wr] = p;
`ifdef SPI_RAM_AUTOINC_EN
        m_wr = m_wr + 8'd1;
`endif
      end
      default: if (!drop) begin
        sq.push_back('{we: 1'b0, addr: m_rd, din: 8'h00});
        sdq.push_back(ref_mem[m_rd]);
`ifdef SPI_RAM_AUTOINC_EN
        m_rd = m_rd + 8'd1;
`endif
      end
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Host request held until the grant pulse is seen
  task automatic host_op(input bit we, input logic [7:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    hq.push_back('{we: we, addr: a, din: d});
    if (we) ref_mem[a] = d;
    else hdq.push_back(ref_mem[a]);
    @(negedge clk);
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (h_gnt) begin
        got = 1'b1;
        break;
      end
    end
    h_req = 1'b0;
    if (!got) chk("host_gnt_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    m_wr = '0;
    m_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    glog.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_h_rvalid"}, h_rvalid, 0);
    chk({tag, "_h_rdata"}, h_rdata, 0);
    chk({tag, "_h_gnt"}, h_gnt, 0);
    chk({tag, "_ram_en"}, ram_en, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_spi_ovf"}, spi_ovf, 0);
  endtask

  task automatic spi_rand(input int n);
    logic [1:0] c;
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      c = 2'($urandom_range(0, 3));
      p = c[0] ? 8'($urandom) : 8'($urandom_range(0, 63));
      spi_word({c, p});
      idle(8);
    end
  endtask

  task automatic host_rand(input int n);
    for (int i = 0; i < n; i++) begin
      host_op(1'($urandom), 8'h80 | 8'($urandom_range(0, 127)), 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    int g;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'hA5;
    ref_mem[8'h10] = 8'hA5;
    m_wr = '0; m_rd = '0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    #1;
    chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // SPI write to 0xFF
    spi_word(10'h0FF);
    spi_word(10'h101);
    idle(6);

    // SPI read of preloaded 0xA5 at 0x10
    spi_word(10'h210);
    spi_word(10'h300);
    idle(8);

    // Contention: SPI wins the first tie, host the next one
    apply_reset();
    spi_word(10'h030);
    spi_word(10'h111);
    fork
      host_op(1'b0, 8'h20, 8'h00);
      begin
        idle(1);
        spi_word(10'h122);
        idle(1);
      end
    join
    idle(8);
    g = 0;
    foreach (glog[i]) g = g * 4 + glog[i];
    chk("grant_count", glog.size(), 3);
    chk("grant_order_SHS", g, 25);

    // Overflow with host held, wr_addr set while slot is full
    apply_reset();
    spi_word(10'h101);
    fork
      host_op(1'b0, 8'h40, 8'h00);
      begin
        spi_word(10'h102, 1'b1);
        spi_word(10'h0AA);
        idle(1);
      end
    join
    idle(4);
    chk("ovf_set", spi_ovf, 1);
    spi_word(10'h133);
    idle(8);
    chk("ovf_sticky", spi_ovf, 1);

    // Reset during RD abandons the read
    apply_reset();
    chk("ovf_cleared", spi_ovf, 0);
    spi_word(10'h210);
    spi_word(10'h300);
    idle(3);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrd");
    sdq.delete();
    scyc.delete();
    m_wr = '0; m_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    idle(8);

    // Consecutive writes (wrap to 0x00 with auto-increment)
    spi_word(10'h0FF);
    spi_word(10'h111);
    idle(6);
    spi_word(10'h122);
    idle(8);

    // Randomized concurrent traffic
    apply_reset();
    fork
      spi_rand(30);
      host_rand(30);
    join
    idle(20);
    chk("spi_ops_left", sq.size(), 0);
    chk("host_ops_left", hq.size(), 0);
    chk("tx_left", sdq.size(), 0);
    chk("hrd_left", hdq.size(), 0);
    chk("rand_no_ovf", spi_ovf, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave's 10-bit receive/transmit words and the single-port RAM.
- Decodes SPI command words into RAM accesses.
- Shares the one RAM port with a second, parallel host requester using round-robin arbitration.
- Sequences each access with a fixed-latency state machine and returns read data to the winning side.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width (SPI word = 2 + DATA_W bits)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx_data  in  DATA_W+2  SPI word: [DATA_W+1:DATA_W] = cmd, [DATA_W-1:0] = payload
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  DATA_W  SPI read data
tx_valid  out  1  one-cycle strobe, tx_data valid
spi_ovf  out  1  sticky: SPI data command dropped
h_req  in  1  host request; held until h_gnt
h_we  in  1  host write (1) / read (0)
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_gnt  out  1  one-cycle grant pulse
h_rdata  out  DATA_W  host read data
h_rvalid  out  1  one-cycle strobe, h_rdata valid
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data, synchronous, valid the cycle after ram_en

Behaviour:
- Reset (async, rst=1) clears all outputs, wr_addr, rd_addr, the pending slot, spi_ovf, last_gnt=HOST and FSM=IDLE.
- Reset mid-access: the in-flight access is abandoned; no tx_valid/h_rvalid follows.
- SPI command decode on rx_valid:
  - 00: wr_addr <= payload[ADDR_W-1:0]; applied the same edge, with no arbitration.
  - 10: rd_addr <= payload; applied the same edge, with no arbitration.
  - 01: write request {we=1, addr=wr_addr, data=payload} into the single-entry pending slot.
  - 11: read request {we=0, addr=rd_addr} into the pending slot; payload ignored.
- The pending slot captures its address at latch time. A later 00/10 does not alter a queued op.
- Pending slot full and rx_valid with cmd 01/11: word dropped, spi_ovf <= 1. spi_ovf is cleared only by rst.
- Commands 00/10 are always accepted, even when the slot is full.
- FSM states: IDLE, ACC, RD.
- IDLE, cycle N:
  - If only one requester is active (pending slot / h_req), it wins.
  - If both are active, the side != last_gnt wins; last_gnt updates to the winner.
  - Registered ram_en/ram_we/ram_addr/ram_din are driven during N+1. FSM -> ACC.
- Host grant: h_gnt pulses in N+1. For an SPI grant, the slot is freed at the end of N+1.
- ACC (N+1):
  - Write: FSM -> IDLE; next arbitration is at N+2.
  - Read: FSM -> RD.
- RD (N+2): ram_dout is registered into tx_data or h_rdata. The matching tx_valid/h_rvalid pulses in N+3. FSM -> IDLE at N+2.
- Read turnaround: back-to-back reads are spaced 3 cycles; writes are spaced 2 cycles.
- ram_en=0 outside ACC. ram_addr/ram_din hold their last value.
- rx_valid arriving in the same cycle the slot is freed (end of N+1) is accepted; no overflow.
- h_req deasserted before h_gnt is legal and withdraws the request.
- Address widths: payload is truncated to ADDR_W bits. With this feature out, wr_addr/rd_addr never change except on 00/10.

Optional Feature:
- SPI_RAM_AUTOINC_EN defined:
  - wr_addr increments by 1 when a 01 op is granted.
  - rd_addr increments by 1 when a 11 op is granted.
  - Both wrap from 2^ADDR_W-1 to 0.
  - A 00/10 in the same cycle as the increment takes priority.
- Undefined: address registers change only on 00/10. Host-side behaviour is identical in both builds.

Test Plan:
- SPI write: rx 0x0FF then 0x101 (cmd 01, data 0x01) -> one ram_en/ram_we cycle with ram_addr=0xFF, ram_din=0x01; tx_valid stays 0.
- SPI read: preload mem[0x10]=0xA5; rx 0x210 then 0x300 -> ram_en with ram_we=0, addr=0x10; tx_data=0xA5 with a one-cycle tx_valid exactly 3 cycles after the grant-decision cycle.
- Contention: host read of 0x20 and SPI write pending in the same IDLE cycle after reset -> SPI granted first. The next simultaneous tie goes to the host, which alternates thereafter.
- Overflow: hold h_req high, send 0x101 then 0x102 while the slot is full -> second word dropped, spi_ovf=1 until rst; 0x0AA during the full slot still updates wr_addr=0xAA.
- Reset mid-read: assert rst during RD -> all outputs 0 immediately; no tx_valid after release.
- With SPI_RAM_AUTOINC_EN: rx 0x0FF, 0x111, 0x122 -> writes to 0xFF then 0x00 (wrap).
